// File: rtl/lpc_pkg.sv
// Shared LPC definitions: FSM states, START / cycle-type / SYNC nibble codes.
package lpc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CYCTYPE,
        ADDR,
        WDATA,
        TAR,
        SYNC,
        RDATA,
        FTAR
    } lpc_state_e;

    localparam logic [3:0] START_LPC  = 4'b0000;
    localparam logic [3:0] START_TPM  = 4'b0101;

    // Cycle type is carried in lad[3:1]; lad[0] is reserved.
    localparam logic [2:0] CYC_IO_RD  = 3'b000;
    localparam logic [2:0] CYC_IO_WR  = 3'b001;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

endpackage

// File: rtl/lpc_addr_match.sv
// Combinational address-window compare; cleared MASK bits are don't-care.
module lpc_addr_match #(
    parameter logic [15:0] BASE = 16'h0000,
    parameter logic [15:0] MASK = 16'hFFF0
) (
    input  logic [15:0] addr,
    output logic        hit
);
    assign hit = ((addr ^ BASE) & MASK) == 16'h0000;
endmodule

// File: rtl/lpc_periph_fsm.sv
// LPC peripheral cycle engine: decodes I/O cycles, hands them to an agent, drives SYNC/data.
// Optional TPM START (0101) support is enabled by defining LPC_TPM_CYCLES_EN.
module lpc_periph_fsm
    import lpc_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE = 16'h0000,
    parameter logic [15:0] ADDR_MASK = 16'hFFF0,
    parameter int          MAX_WAIT  = 15
) (
    input  logic        lclk_i,
    input  logic        lreset,
    input  logic        lframe_i,
    input  logic [3:0]  lad_i,
    output logic [3:0]  lad_o,
    output logic        lad_oe,
    output logic        req_o,
    output logic        wr_o,
    output logic        tpm_o,
    output logic [15:0] addr_o,
    output logic [7:0]  wdata_o,
    input  logic [7:0]  rdata_i,
    input  logic        ack_i,
    output logic        abort_o
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    lpc_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        req_q, req_d;
    logic        ack_seen_q, ack_seen_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  lad_o_d;
    logic        lad_oe_d;
    logic        abort_d;
    logic        is_start;
    logic        ack_acc;
    logic        hit;
    logic [15:0] addr_shift;

    assign addr_shift = {addr_q[11:0], lad_i};
    assign ack_acc    = ack_i & req_q;

    lpc_addr_match #(.BASE(ADDR_BASE), .MASK(ADDR_MASK)) u_match (
        .addr (addr_shift),
        .hit  (hit)
    );

`ifdef LPC_TPM_CYCLES_EN
    logic tpm_q, tpm_d;
    assign is_start = (lad_i == START_LPC) || (lad_i == START_TPM);
    assign tpm_o    = tpm_q;
`else
    assign is_start = (lad_i == START_LPC);
    assign tpm_o    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wr_d       = wr_q;
        req_d      = req_q;
        ack_seen_d = ack_seen_q;
        wait_d     = wait_q;
        lad_o_d    = 4'hF;
        lad_oe_d   = 1'b0;
        abort_d    = 1'b0;
`ifdef LPC_TPM_CYCLES_EN
        tpm_d      = tpm_q;
`endif

        if (ack_acc) begin
            req_d      = 1'b0;
            ack_seen_d = 1'b1;
            rdata_d    = rdata_i;
        end

        // lad_o/lad_oe next values describe what is driven during the next state's clock.
        case (state_q)
            IDLE: ;
            CYCTYPE: begin
                cnt_d = 2'd0;
                if (lad_i[3:1] == CYC_IO_RD) begin
                    wr_d    = 1'b0;
                    state_d = ADDR;
                end else if (lad_i[3:1] == CYC_IO_WR) begin
                    wr_d    = 1'b1;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                addr_d = addr_shift;
                cnt_d  = 2'(cnt_q + 2'd1);
                if (cnt_q == 2'd3) begin
                    cnt_d = 2'd0;
                    if (!hit) begin
                        state_d = IDLE;
                    end else if (wr_q) begin
                        state_d = WDATA;
                    end else begin
                        state_d = TAR;
                        req_d   = 1'b1;
                    end
                end
            end
            WDATA: begin
                cnt_d = 2'(cnt_q + 2'd1);
                if (cnt_q == 2'd0) begin
                    wdata_d[3:0] = lad_i;
                end else begin
                    wdata_d[7:4] = lad_i;
                    cnt_d        = 2'd0;
                    state_d      = TAR;
                    req_d        = 1'b1;
                end
            end
            TAR: begin
                cnt_d = 2'(cnt_q + 2'd1);
                if (cnt_q != 2'd0) begin
                    state_d  = SYNC;
                    lad_oe_d = 1'b1;
                    if (ack_seen_q || ack_acc) begin
                        lad_o_d = SYNC_READY;
                    end else begin
                        lad_o_d = SYNC_LWAIT;
                        wait_d  = 8'd1;
                    end
                end
            end
            SYNC: begin
                lad_oe_d = 1'b1;
                cnt_d    = 2'd0;
                if (lad_o == SYNC_LWAIT) begin
                    if (ack_acc) begin
                        lad_o_d = SYNC_READY;
                    end else if (wait_q >= MAX_W) begin
                        lad_o_d = SYNC_ERROR;
                        req_d   = 1'b0;
                        rdata_d = 8'hFF;
                    end else begin
                        lad_o_d = SYNC_LWAIT;
                        wait_d  = 8'(wait_q + 8'd1);
                    end
                end else if (wr_q) begin
                    state_d = FTAR;
                    lad_o_d = 4'hF;
                end else begin
                    state_d = RDATA;
                    lad_o_d = rdata_q[3:0];
                end
            end
            RDATA: begin
                lad_oe_d = 1'b1;
                if (cnt_q == 2'd0) begin
                    cnt_d   = 2'd1;
                    lad_o_d = rdata_q[7:4];
                end else begin
                    cnt_d   = 2'd0;
                    state_d = FTAR;
                    lad_o_d = 4'hF;
                end
            end
            FTAR: begin
                if (cnt_q == 2'd0) cnt_d = 2'd1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // LFRAME# low overrides everything; an active cycle is torn down with an abort pulse.
        if (!lframe_i) begin
            state_d    = is_start ? CYCTYPE : IDLE;
            lad_o_d    = 4'hF;
            lad_oe_d   = 1'b0;
            ack_seen_d = 1'b0;
            if (lad_oe || req_q) begin
                abort_d = 1'b1;
                req_d   = 1'b0;
            end
`ifdef LPC_TPM_CYCLES_EN
            if (is_start) tpm_d = (lad_i == START_TPM);
`endif
        end
    end

    always_ff @(posedge lclk_i) begin
        if (lreset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            req_q      <= 1'b0;
            ack_seen_q <= 1'b0;
            wait_q     <= 8'd0;
            lad_o      <= 4'hF;
            lad_oe     <= 1'b0;
            abort_o    <= 1'b0;
`ifdef LPC_TPM_CYCLES_EN
            tpm_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wr_q       <= wr_d;
            req_q      <= req_d;
            ack_seen_q <= ack_seen_d;
            wait_q     <= wait_d;
            lad_o      <= lad_o_d;
            lad_oe     <= lad_oe_d;
            abort_o    <= abort_d;
`ifdef LPC_TPM_CYCLES_EN
            tpm_q      <= tpm_d;
`endif
        end
    end

    assign req_o   = req_q;
    assign wr_o    = wr_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_lpc_periph_fsm.sv
// Directed bench for lpc_periph_fsm: read, write, miss, timeout, abort, TPM start, reset.
module tb_lpc_periph_fsm;

    logic        lclk_i = 1'b0;
    logic        lreset;
    logic        lframe_i;
    logic [3:0]  lad_i;
    logic [3:0]  lad_o;
    logic        lad_oe;
    logic        req_o;
    logic        wr_o;
    logic        tpm_o;
    logic [15:0] addr_o;
    logic [7:0]  wdata_o;
    logic [7:0]  rdata_i;
    logic        ack_i;
    logic        abort_o;

    int nvec = 0;
    int nerr = 0;

    always #5 lclk_i = ~lclk_i;

    lpc_periph_fsm #(
        .ADDR_BASE (16'h0FF0),
        .ADDR_MASK (16'hFFF0),
        .MAX_WAIT  (4)
    ) dut (
        .lclk_i   (lclk_i),
        .lreset   (lreset),
        .lframe_i (lframe_i),
        .lad_i    (lad_i),
        .lad_o    (lad_o),
        .lad_oe   (lad_oe),
        .req_o    (req_o),
        .wr_o     (wr_o),
        .tpm_o    (tpm_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .rdata_i  (rdata_i),
        .ack_i    (ack_i),
        .abort_o  (abort_o)
    );

    // Drive one LPC clock's inputs at the falling edge; outputs seen right after
    // a step are the values the DUT presents during that same clock.
    task automatic step(input logic f, input logic [3:0] l, input logic a);
        @(negedge lclk_i);
        lframe_i = f;
        lad_i    = l;
        ack_i    = a;
    endtask

    task automatic send_hdr(input logic [3:0] st, input logic [3:0] cyc, input logic [15:0] a);
        step(1'b0, st, 1'b0);
        step(1'b1, cyc, 1'b0);
        for (int i = 3; i >= 0; i--) step(1'b1, a[i*4 +: 4], 1'b0);
    endtask

    task automatic test_reset;
        lreset = 1'b1; lframe_i = 1'b1; lad_i = 4'hF; ack_i = 1'b0; rdata_i = 8'h00;
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if ({lad_oe, lad_o} !== {1'b0, 4'hF}) begin
            nerr++; $display("FAIL reset_lad: oe/lad=%b/%h expected 0/f", lad_oe, lad_o);
        end
        nvec++;
        if ({req_o, wr_o, tpm_o, abort_o, addr_o, wdata_o} !== 28'h0) begin
            nerr++; $display("FAIL reset_outs: req=%b wr=%b tpm=%b abort=%b addr=%h wdata=%h expected all 0",
                             req_o, wr_o, tpm_o, abort_o, addr_o, wdata_o);
        end
        lreset = 1'b0;
        step(1'b1, 4'hF, 1'b0);
    endtask

    task automatic test_io_read;
        logic [4:0] exp [5];
        exp = '{5'h10, 5'h15, 5'h1A, 5'h1F, 5'h0F};
        rdata_i = 8'hA5;
        send_hdr(4'h0, 4'h0, 16'h0FF4);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if ({req_o, wr_o, lad_oe, addr_o} !== {3'b100, 16'h0FF4}) begin
            nerr++; $display("FAIL read_tar1: req/wr/oe=%b%b%b addr=%h expected 100 0ff4", req_o, wr_o, lad_oe, addr_o);
        end
        step(1'b1, 4'hF, 1'b1);
        nvec++;
        if (lad_oe !== 1'b0) begin
            nerr++; $display("FAIL read_tar2: oe=%b expected 0", lad_oe);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 1'b0);
            nvec++;
            if ({lad_oe, lad_o} !== exp[i]) begin
                nerr++; $display("FAIL read_bus c%0d: oe/lad=%b/%h expected %b/%h", i, lad_oe, lad_o, exp[i][4], exp[i][3:0]);
            end
            if (i == 0) begin
                nvec++;
                if (req_o !== 1'b0) begin
                    nerr++; $display("FAIL read_req_drop: req=%b expected 0", req_o);
                end
            end
        end
        step(1'b1, 4'hF, 1'b0);
    endtask

    task automatic test_io_write;
        logic [4:0] exp [6];
        exp = '{5'h16, 5'h16, 5'h16, 5'h10, 5'h1F, 5'h0F};
        send_hdr(4'h0, 4'h2, 16'h0FF8);
        step(1'b1, 4'hC, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if ({req_o, wr_o, wdata_o, addr_o} !== {2'b11, 8'h3C, 16'h0FF8}) begin
            nerr++; $display("FAIL write_req: req/wr=%b%b wdata=%h addr=%h expected 11 3c 0ff8", req_o, wr_o, wdata_o, addr_o);
        end
        step(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'hF, i == 2);
            nvec++;
            if ({lad_oe, lad_o} !== exp[i]) begin
                nerr++; $display("FAIL write_bus c%0d: oe/lad=%b/%h expected %b/%h", i, lad_oe, lad_o, exp[i][4], exp[i][3:0]);
            end
        end
        step(1'b1, 4'hF, 1'b0);
    endtask

    task automatic test_miss;
        send_hdr(4'h0, 4'h0, 16'h0060);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'hF, 1'b0);
            nvec++;
            if ({lad_oe, req_o} !== 2'b00) begin
                nerr++; $display("FAIL miss c%0d: oe/req=%b%b expected 00", i, lad_oe, req_o);
            end
        end
    endtask

    task automatic test_timeout;
        logic [4:0] exp [9];
        exp = '{5'h16, 5'h16, 5'h16, 5'h16, 5'h1A, 5'h1F, 5'h1F, 5'h1F, 5'h0F};
        send_hdr(4'h0, 4'h0, 16'h0FF2);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if (req_o !== 1'b1) begin
            nerr++; $display("FAIL timeout_req: req=%b expected 1", req_o);
        end
        step(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'hF, 1'b0);
            nvec++;
            if ({lad_oe, lad_o} !== exp[i]) begin
                nerr++; $display("FAIL timeout_bus c%0d: oe/lad=%b/%h expected %b/%h", i, lad_oe, lad_o, exp[i][4], exp[i][3:0]);
            end
            if (i == 4) begin
                nvec++;
                if (req_o !== 1'b0) begin
                    nerr++; $display("FAIL timeout_req_drop: req=%b expected 0", req_o);
                end
            end
        end
        step(1'b1, 4'hF, 1'b0);
    endtask

    task automatic test_abort;
        logic [4:0] exp [5];
        exp = '{5'h10, 5'h1A, 5'h15, 5'h1F, 5'h0F};
        send_hdr(4'h0, 4'h0, 16'h0FF4);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if ({lad_oe, lad_o} !== 5'h16) begin
            nerr++; $display("FAIL abort_sync1: oe/lad=%b/%h expected 1/6", lad_oe, lad_o);
        end
        step(1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        nvec++;
        if ({abort_o, lad_oe, req_o} !== 3'b100) begin
            nerr++; $display("FAIL abort_pulse: abort/oe/req=%b%b%b expected 100", abort_o, lad_oe, req_o);
        end
        step(1'b1, 4'h0, 1'b0);
        nvec++;
        if (abort_o !== 1'b0) begin
            nerr++; $display("FAIL abort_single: abort=%b expected 0", abort_o);
        end
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        rdata_i = 8'h5A;
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if ({req_o, addr_o} !== {1'b1, 16'h0FF8}) begin
            nerr++; $display("FAIL abort_newcyc: req=%b addr=%h expected 1 0ff8", req_o, addr_o);
        end
        step(1'b1, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 1'b0);
            nvec++;
            if ({lad_oe, lad_o} !== exp[i]) begin
                nerr++; $display("FAIL abort_bus c%0d: oe/lad=%b/%h expected %b/%h", i, lad_oe, lad_o, exp[i][4], exp[i][3:0]);
            end
        end
        step(1'b1, 4'hF, 1'b0);
    endtask

    task automatic test_tpm;
        send_hdr(4'h5, 4'h0, 16'h0FF4);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
`ifdef LPC_TPM_CYCLES_EN
        if ({req_o, tpm_o} !== 2'b11) begin
            nerr++; $display("FAIL tpm_req: req/tpm=%b%b expected 11", req_o, tpm_o);
        end
`else
        if ({req_o, tpm_o} !== 2'b00) begin
            nerr++; $display("FAIL tpm_req: req/tpm=%b%b expected 00", req_o, tpm_o);
        end
`endif
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
`ifdef LPC_TPM_CYCLES_EN
        if ({lad_oe, lad_o} !== 5'h10) begin
            nerr++; $display("FAIL tpm_sync: oe/lad=%b/%h expected 1/0", lad_oe, lad_o);
        end
`else
        if (lad_oe !== 1'b0) begin
            nerr++; $display("FAIL tpm_sync: oe=%b expected 0", lad_oe);
        end
`endif
        repeat (5) step(1'b1, 4'hF, 1'b0);
    endtask

    task automatic test_reset_mid;
        send_hdr(4'h0, 4'h0, 16'h0FF4);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if ({lad_oe, req_o} !== 2'b11) begin
            nerr++; $display("FAIL rstmid_pre: oe/req=%b%b expected 11", lad_oe, req_o);
        end
        lreset = 1'b1;
        step(1'b1, 4'hF, 1'b0);
        nvec++;
        if ({lad_oe, lad_o, req_o, addr_o} !== {1'b0, 4'hF, 1'b0, 16'h0000}) begin
            nerr++; $display("FAIL rstmid_post: oe/lad=%b/%h req=%b addr=%h expected 0/f 0 0000",
                             lad_oe, lad_o, req_o, addr_o);
        end
        lreset = 1'b0;
        step(1'b1, 4'hF, 1'b0);
    endtask

    initial begin
        test_reset;
        test_io_read;
        test_io_write;
        test_miss;
        test_timeout;
        test_abort;
        test_tpm;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lpc_periph_fsm.md
# lpc_periph_fsm

Parametrised LPC peripheral-side cycle engine, successor to the fixed IO-read responder in the LPC test top. Decodes LPC I/O read/write (and optionally TPM read/write) cycles on LAD[3:0], matches the 16-bit address against a configurable window, and hands each accepted access to a register-side agent through a req/ack handshake. It inserts long-wait SYNCs until the agent acknowledges, and reports an error SYNC on timeout. The LAD tristate buffer is instantiated at the top level, not in this block.

## Interface
- ADDR_BASE, 16'h0000: window base address.
- ADDR_MASK, 16'hFFF0: address bits compared against ADDR_BASE; a cleared bit means don't-care.
- MAX_WAIT, 15: number of long-wait SYNC (0110) clocks before error SYNC; range 1..255.
- lclk_i  in  1  LPC clock (33 MHz); all logic is on its rising edge.
- lreset  in  1  synchronous, active-high reset.
- lframe_i  in  1  LFRAME#, active-low.
- lad_i  in  4  LAD sampled input.
- lad_o  out  4  LAD drive value, registered.
- lad_oe  out  1  LAD output enable, registered.
- req_o  out  1  access request, held until ack_i.
- wr_o  out  1  1 = write; valid while req_o.
- tpm_o  out  1  cycle used the TPM start code; valid while req_o.
- addr_o  out  16  access address; valid while req_o.
- wdata_o  out  8  write data; valid while req_o && wr_o.
- rdata_i  in  8  read data, captured on the ack_i cycle.
- ack_i  in  1  agent completion, single-cycle pulse.
- abort_o  out  1  one-cycle pulse when an accepted cycle is aborted.

## Operation
- States: IDLE, CYCTYPE, ADDR, WDATA, TAR, SYNC, RDATA, FTAR.
- Start detect, from any state: lframe_i=0 with lad_i=0000 (or 0101 when TPM is enabled) arms CYCTYPE. The last START nibble before lframe_i rises wins. If this happens while lad_oe=1 or req_o=1, pulse abort_o, drop req_o, and force lad_oe=0 on the next edge.
- CYCTYPE: lframe_i=1, lad_i[3:1] = 000 (read) or 001 (write), lad_i[0] ignored. Any other value → IDLE.
- ADDR: 4 clocks, MSB nibble first, with a 2-bit counter. After the last nibble, on a window miss ((addr ^ ADDR_BASE) & ADDR_MASK ≠ 0) → IDLE, never driving LAD.
- WDATA (writes only): 2 clocks, low nibble first, into wdata_o.
- TAR: 2 clocks; the host drives 1111; lad_oe=0. req_o asserts on entry to TAR.
- SYNC: lad_oe=1. Drives 0110 while ack_i has not been seen and the wait count is below MAX_WAIT.
  - ack_i seen → drive 0000 and capture rdata_i.
  - Count reaches MAX_WAIT → drive 1010 (error) and drop req_o. Read data then returns 8'hFF.
- RDATA (reads only): 2 clocks, low nibble first.
- FTAR: clock 1 drives 1111 with lad_oe=1; clock 2 has lad_oe=0; then → IDLE.
- ack_i is ignored when req_o=0. An ack_i during TAR is accepted, and SYNC then starts directly with 0000.

## Timing
- Reset values: state IDLE; lad_o=4'hF, lad_oe=0, req_o=0, wr_o=0, tpm_o=0, addr_o=0, wdata_o=0, abort_o=0.
- lad_o and lad_oe change one clock after the state that requests them, with no combinational path from lad_i.
- Minimum IO read with ack_i during TAR: START→FTAR end = 13 clocks. Each long wait adds 1 clock.
- ack_i in cycle n → lad_o=0000 at edge n+1.
- Reset mid-cycle: next edge returns all outputs to reset values and releases LAD.

## Configuration
- LPC_TPM_CYCLES_EN defined: START 0101 is accepted and tpm_o reflects it.
- LPC_TPM_CYCLES_EN undefined: only START 0000 is accepted, 0101 is ignored, and tpm_o is tied to 0.

## Structure
- Package lpc_pkg holds:
  - state enum;
  - START codes (0000, 0101);
  - cycle-type codes;
  - SYNC codes: READY 0000, LWAIT 0110, ERROR 1010.
- One sub-module, lpc_addr_match: purely combinational window compare, reused by later LPC blocks.

## Test plan
- IO read 0x0FF4 (BASE 0x0FF0, MASK 0xFFF0), ack_i in TAR2, rdata_i=8'hA5 → SYNC 0000, LAD nibbles 5, A, then 1111; lad_oe released at FTAR2.
- IO write 0x0FF8, data 8'h3C, ack_i after 3 waits → wdata_o=3C, wr_o=1, three 0110 SYNCs then 0000.
- IO read 0x0060 (miss) → lad_oe stays 0 for the whole cycle, req_o never asserts.
- MAX_WAIT=4, no ack_i → four 0110, then 1010, data FF, req_o drops.
- lframe_i low with 0000 during the SYNC wait → abort_o pulse, lad_oe=0 next edge, new cycle decoded correctly.
- TPM start 0101: with LPC_TPM_CYCLES_EN → tpm_o=1 and access served; without → no response.
